lockin_polar_converter: RTL and testbench

Converts the lock-in amplifier's Cartesian outputs (in-phase X, quadrature Y) into amplitude and phase using an iterative CORDIC in vectoring mode. Sits directly downstream of the lock-in amplifier, sampling X/Y on the same 10 µs tick that paces the lock-in filters. Produces one amplitude/phase pair per tick for the telemetry and phase-tracking path.

---
 rtl/lockin_pkg.sv | 20 ++
 rtl/cordic_vector_stage.sv | 35 +++
 rtl/lockin_polar_converter.sv | 140 ++++++++++++++
 tb/tb_lockin_polar_converter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lockin_pkg.sv
// rtl/lockin_pkg.sv - arctangent table, gain constant and FSM encoding for the lock-in polar converter
package lockin_pkg;

    localparam int ATAN_BITS  = 24;
    localparam int ATAN_DEPTH = 22;

    // round(atan(2^-i) / pi * 2^23): binary angle where 2^23 represents pi
    localparam logic signed [ATAN_BITS-1:0] ATAN [ATAN_DEPTH] = '{
        24'sd2097152, 24'sd1238021, 24'sd654136, 24'sd332050, 24'sd166669,
        24'sd83416,   24'sd41718,   24'sd20860,  24'sd10430,  24'sd5215,
        24'sd2608,    24'sd1304,    24'sd652,    24'sd326,    24'sd163,
        24'sd81,      24'sd41,      24'sd20,     24'sd10,     24'sd5,
        24'sd3,       24'sd1
    };

    localparam int K_INV = 5094007;

    typedef enum logic [2:0] {IDLE, PREROT, ITER, SCALE, DONE} state_t;

endpackage

// File: rtl/cordic_vector_stage.sv
// rtl/cordic_vector_stage.sv - one combinational vectoring-mode CORDIC micro-rotation
module cordic_vector_stage #(
    parameter int XY_BITS    = 26,
    parameter int Z_BITS     = 24,
    parameter int SHIFT_BITS = 5
) (
    input  logic signed [XY_BITS-1:0]  x,
    input  logic signed [XY_BITS-1:0]  y,
    input  logic signed [Z_BITS-1:0]   z,
    input  logic        [SHIFT_BITS-1:0] i,
    input  logic signed [Z_BITS-1:0]   atan,
    output logic signed [XY_BITS-1:0]  x_next,
    output logic signed [XY_BITS-1:0]  y_next,
    output logic signed [Z_BITS-1:0]   z_next
);

    logic signed [XY_BITS-1:0] x_shift;
    logic signed [XY_BITS-1:0] y_shift;

    assign x_shift = x >>> i;
    assign y_shift = y >>> i;

    // Rotate toward the positive x axis: direction chosen by the sign of y
    always_comb begin
        x_next = x + y_shift;
        y_next = y - x_shift;
        z_next = z + atan;
        if (y[XY_BITS-1]) begin
            x_next = x - y_shift;
            y_next = y + x_shift;
            z_next = z - atan;
        end
    end

endmodule

// File: rtl/lockin_polar_converter.sv
// rtl/lockin_polar_converter.sv - iterative CORDIC converting lock-in X/Y into amplitude and phase
import lockin_pkg::*;

module lockin_polar_converter #(
    parameter int NUM_BITS   = 24,
    parameter int NUM_ITER   = 20,
    parameter int GUARD_BITS = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       tick_i,
    input  logic signed [NUM_BITS-1:0] x_i,
    input  logic signed [NUM_BITS-1:0] y_i,
    output logic        [NUM_BITS-1:0] amplitude_o,
    output logic signed [NUM_BITS-1:0] phase_o,
    output logic                       valid_o,
    output logic                       busy_o,
    output logic                       overrun_o
);

    localparam int XY_BITS   = NUM_BITS + GUARD_BITS;
    localparam int CNT_BITS  = $clog2(NUM_ITER);
    localparam int PROD_BITS = XY_BITS + NUM_BITS + 1;
    localparam logic signed [PROD_BITS-1:0] K_INV_EXT = PROD_BITS'(K_INV);
    // pi as a binary angle; seed for vectors in the left half plane
    localparam logic signed [NUM_BITS-1:0] Z_PI = {1'b1, {(NUM_BITS-1){1'b0}}};

    state_t state;
    state_t state_next;

    logic signed [NUM_BITS-1:0] x_in;
    logic signed [NUM_BITS-1:0] y_in;
    logic signed [XY_BITS-1:0]  x_ext;
    logic signed [XY_BITS-1:0]  y_ext;
    logic signed [XY_BITS-1:0]  x_acc;
    logic signed [XY_BITS-1:0]  y_acc;
    logic signed [XY_BITS-1:0]  x_rot;
    logic signed [XY_BITS-1:0]  y_rot;
    logic signed [NUM_BITS-1:0] z_acc;
    logic signed [NUM_BITS-1:0] z_rot;
    logic signed [NUM_BITS-1:0] atan_i;
    logic [CNT_BITS-1:0]        iter;
    logic                       zero_in;

    assign x_ext   = XY_BITS'(x_in);
    assign y_ext   = XY_BITS'(y_in);
    assign atan_i  = NUM_BITS'(ATAN[iter]);
    assign zero_in = (x_in == '0) && (y_in == '0);
    assign busy_o  = (state != IDLE);

    cordic_vector_stage #(
        .XY_BITS    (XY_BITS),
        .Z_BITS     (NUM_BITS),
        .SHIFT_BITS (CNT_BITS)
    ) u_stage (
        .x      (x_acc),
        .y      (y_acc),
        .z      (z_acc),
        .i      (iter),
        .atan   (atan_i),
        .x_next (x_rot),
        .y_next (y_rot),
        .z_next (z_rot)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick_i) state_next = PREROT;
            PREROT:  state_next = ITER;
            ITER:    if (iter == CNT_BITS'(NUM_ITER - 1)) state_next = SCALE;
            SCALE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            x_in        <= '0;
            y_in        <= '0;
            x_acc       <= '0;
            y_acc       <= '0;
            z_acc       <= '0;
            iter        <= '0;
            amplitude_o <= '0;
            phase_o     <= '0;
            valid_o     <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (tick_i && state != IDLE) begin
                overrun_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick_i) begin
                        x_in <= x_i;
                        y_in <= y_i;
                    end
                end
                PREROT: begin
                    // Fold the left half plane onto the right so the iterations converge
                    if (x_in[NUM_BITS-1]) begin
                        x_acc <= -x_ext;
                        y_acc <= -y_ext;
                        z_acc <= Z_PI;
                    end else begin
                        x_acc <= x_ext;
                        y_acc <= y_ext;
                        z_acc <= '0;
                    end
                    iter <= '0;
                end
                ITER: begin
                    x_acc <= x_rot;
                    y_acc <= y_rot;
                    z_acc <= z_rot;
                    iter  <= iter + CNT_BITS'(1);
                end
                SCALE: begin
                    amplitude_o <= zero_in ? '0
                                 : NUM_BITS'((PROD_BITS'(x_acc) * K_INV_EXT) >>> (NUM_BITS - 1));
                    phase_o     <= zero_in ? '0 : z_acc;
                    valid_o     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lockin_polar_converter.sv
// tb/tb_lockin_polar_converter.sv - randomized self-checking bench for lockin_polar_converter
module tb_lockin_polar_converter;

    localparam real PI       = 3.14159265358979323846;
    localparam real HALF     = 8388608.0;
    localparam real AMP_TOL  = 16.0;
    localparam real PH_TOL   = 32.0;
    localparam int  LATENCY  = 23;

    logic               clk = 1'b0;
    logic               reset_i;
    logic               tick_i;
    logic signed [23:0] x_i;
    logic signed [23:0] y_i;
    logic        [23:0] amplitude_o;
    logic signed [23:0] phase_o;
    logic               valid_o;
    logic               busy_o;
    logic               overrun_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lockin_polar_converter dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .tick_i      (tick_i),
        .x_i         (x_i),
        .y_i         (y_i),
        .amplitude_o (amplitude_o),
        .phase_o     (phase_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o)
    );

    function automatic real ref_amp(input int x, input int y);
        return $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    endfunction

    function automatic real ref_phase(input int x, input int y);
        if (x == 0 && y == 0) return 0.0;
        return $atan2(real'(y), real'(x)) / PI * HALF;
    endfunction

    function automatic real phase_err(input logic signed [23:0] p, input real r);
        real d;
        d = real'(p) - r;
        if (d > HALF) d = d - 2.0 * HALF;
        else if (d < -HALF) d = d + 2.0 * HALF;
        return d;
    endfunction

    function automatic real absr(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    task automatic convert(input int x, input int y, output logic [23:0] amp,
                           output logic signed [23:0] ph, output int lat);
        @(negedge clk);
        tick_i = 1'b1;
        x_i = 24'(x);
        y_i = 24'(y);
        @(negedge clk);
        tick_i = 1'b0;
        lat = -1;
        amp = '0;
        ph = '0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (valid_o) begin
                lat = k;
                amp = amplitude_o;
                ph = phase_o;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick_i = 1'b0;
        x_i = '0;
        y_i = '0;
        repeat (3) @(negedge clk);
        reset_i = 1'b0;
        repeat (30) begin
            @(negedge clk);
            vectors++;
            if ({amplitude_o, phase_o, valid_o, busy_o, overrun_o} !== 51'd0) begin
                miscompares++;
                $display("FAIL reset_idle: amp=%0d phase=%0d valid=%0b busy=%0b overrun=%0b, required all 0",
                         amplitude_o, phase_o, valid_o, busy_o, overrun_o);
            end
        end
    endtask

    task automatic test_cardinal();
        int xs [4] = '{4194304, 0, -4194304, 0};
        int ys [4] = '{0, 4194304, 0, -4194304};
        logic [23:0] amp;
        logic signed [23:0] ph;
        int lat;
        for (int n = 0; n < 4; n++) begin
            convert(xs[n], ys[n], amp, ph, lat);
            vectors++;
            if (lat !== LATENCY) begin
                miscompares++;
                $display("FAIL cardinal%0d_latency: got %0d, required %0d", n, lat, LATENCY);
            end
            vectors++;
            if (absr(real'(amp) - ref_amp(xs[n], ys[n])) > AMP_TOL) begin
                miscompares++;
                $display("FAIL cardinal%0d_amp: got %0d, required %f +-16", n, amp, ref_amp(xs[n], ys[n]));
            end
            vectors++;
            if (absr(phase_err(ph, ref_phase(xs[n], ys[n]))) > PH_TOL) begin
                miscompares++;
                $display("FAIL cardinal%0d_phase: got %0d, required %f +-32", n, ph, ref_phase(xs[n], ys[n]));
            end
        end
    endtask

    task automatic test_corners();
        int xs [3] = '{3000000, -8388608, 0};
        int ys [3] = '{3000000, -8388608, 0};
        logic [23:0] amp;
        logic signed [23:0] ph;
        int lat;
        for (int n = 0; n < 3; n++) begin
            convert(xs[n], ys[n], amp, ph, lat);
            vectors++;
            if (lat !== LATENCY) begin
                miscompares++;
                $display("FAIL corner%0d_latency: got %0d, required %0d", n, lat, LATENCY);
            end
            if (xs[n] == 0 && ys[n] == 0) begin
                vectors++;
                if (amp !== 24'd0 || ph !== 24'sd0) begin
                    miscompares++;
                    $display("FAIL corner_zero: got amp=%0d phase=%0d, required 0 0", amp, ph);
                end
            end else begin
                vectors++;
                if (absr(real'(amp) - ref_amp(xs[n], ys[n])) > AMP_TOL) begin
                    miscompares++;
                    $display("FAIL corner%0d_amp: got %0d, required %f +-16", n, amp, ref_amp(xs[n], ys[n]));
                end
                vectors++;
                if (absr(phase_err(ph, ref_phase(xs[n], ys[n]))) > PH_TOL) begin
                    miscompares++;
                    $display("FAIL corner%0d_phase: got %0d, required %f +-32", n, ph, ref_phase(xs[n], ys[n]));
                end
            end
        end
    endtask

    task automatic test_latency_busy();
        @(negedge clk);
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_before_tick: got %0b, required 0", busy_o);
        end
        tick_i = 1'b1;
        x_i = 24'sd1234567;
        y_i = -24'sd2345678;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            tick_i = 1'b0;
            vectors++;
            if (busy_o !== (k <= LATENCY) || valid_o !== (k == LATENCY)) begin
                miscompares++;
                $display("FAIL timing_T+%0d: got busy=%0b valid=%0b, required busy=%0b valid=%0b",
                         k, busy_o, valid_o, k <= LATENCY, k == LATENCY);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] amp;
        logic signed [23:0] ph;
        int lat;
        int x;
        int y;
        for (int n = 0; n < 20; n++) begin
            do begin
                x = int'($urandom) >>> 8;
                y = int'($urandom) >>> 8;
            end while (ref_amp(x, y) < 1048576.0);
            convert(x, y, amp, ph, lat);
            vectors++;
            if (lat !== LATENCY) begin
                miscompares++;
                $display("FAIL rand%0d_latency: got %0d, required %0d", n, lat, LATENCY);
            end
            vectors++;
            if (absr(real'(amp) - ref_amp(x, y)) > AMP_TOL) begin
                miscompares++;
                $display("FAIL rand%0d_amp: x=%0d y=%0d got %0d, required %f +-16", n, x, y, amp, ref_amp(x, y));
            end
            vectors++;
            if (absr(phase_err(ph, ref_phase(x, y))) > PH_TOL) begin
                miscompares++;
                $display("FAIL rand%0d_phase: x=%0d y=%0d got %0d, required %f +-32", n, x, y, ph, ref_phase(x, y));
            end
        end
        vectors++;
        if (overrun_o !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_back_overrun: got %0b, required 0", overrun_o);
        end
    endtask

    task automatic test_overrun();
        logic [23:0] amp;
        logic signed [23:0] ph;
        int lat;
        int x1 = 5000000;
        int y1 = -2000000;
        @(negedge clk);
        tick_i = 1'b1;
        x_i = 24'(x1);
        y_i = 24'(y1);
        @(negedge clk);
        tick_i = 1'b0;
        lat = -1;
        amp = '0;
        ph = '0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            tick_i = (k == 10);
            if (k == 10) begin
                x_i = -24'sd3000000;
                y_i = 24'sd6000000;
            end
            if (valid_o) begin
                lat = k;
                amp = amplitude_o;
                ph = phase_o;
                break;
            end
        end
        tick_i = 1'b0;
        vectors++;
        if (lat !== LATENCY) begin
            miscompares++;
            $display("FAIL overrun_latency: got %0d, required %0d", lat, LATENCY);
        end
        vectors++;
        if (absr(real'(amp) - ref_amp(x1, y1)) > AMP_TOL) begin
            miscompares++;
            $display("FAIL overrun_amp: got %0d, required %f +-16", amp, ref_amp(x1, y1));
        end
        vectors++;
        if (absr(phase_err(ph, ref_phase(x1, y1))) > PH_TOL) begin
            miscompares++;
            $display("FAIL overrun_phase: got %0d, required %f +-32", ph, ref_phase(x1, y1));
        end
        vectors++;
        if (overrun_o !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set: got %0b, required 1", overrun_o);
        end
        convert(-1500000, -700000, amp, ph, lat);
        vectors++;
        if (overrun_o !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_sticky: got %0b, required 1", overrun_o);
        end
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        vectors++;
        if (overrun_o !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clear: got %0b, required 0", overrun_o);
        end
    endtask

    task automatic test_mid_reset();
        logic [23:0] amp;
        logic signed [23:0] ph;
        int lat;
        int seen_valid = 0;
        convert(2500000, 3500000, amp, ph, lat);
        @(negedge clk);
        tick_i = 1'b1;
        x_i = 24'sd6000000;
        y_i = 24'sd100000;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            tick_i = 1'b0;
            if (valid_o) seen_valid++;
        end
        reset_i = 1'b1;
        @(negedge clk);
        vectors++;
        if (amplitude_o !== 24'd0 || phase_o !== 24'sd0 || busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_clear: got amp=%0d phase=%0d busy=%0b, required 0 0 0",
                     amplitude_o, phase_o, busy_o);
        end
        tick_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        tick_i = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (valid_o || busy_o) seen_valid++;
        end
        vectors++;
        if (seen_valid !== 0) begin
            miscompares++;
            $display("FAIL mid_reset_no_valid: got %0d valid/busy cycles, required 0", seen_valid);
        end
        convert(-4000000, 2000000, amp, ph, lat);
        vectors++;
        if (lat !== LATENCY) begin
            miscompares++;
            $display("FAIL after_reset_latency: got %0d, required %0d", lat, LATENCY);
        end
        vectors++;
        if (absr(real'(amp) - ref_amp(-4000000, 2000000)) > AMP_TOL) begin
            miscompares++;
            $display("FAIL after_reset_amp: got %0d, required %f +-16", amp, ref_amp(-4000000, 2000000));
        end
        vectors++;
        if (absr(phase_err(ph, ref_phase(-4000000, 2000000))) > PH_TOL) begin
            miscompares++;
            $display("FAIL after_reset_phase: got %0d, required %f +-32", ph, ref_phase(-4000000, 2000000));
        end
    endtask

    initial begin
        reset_i = 1'b1;
        tick_i = 1'b0;
        x_i = '0;
        y_i = '0;
        test_reset();
        test_cardinal();
        test_corners();
        test_latency_busy();
        test_back_to_back();
        test_overrun();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
